iomem_timer: RTL

IOMEM_TIMER -- requirements
Module: iomem_timer

---
 rtl/iomem_timer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// ----------------------------------------------------------------------------
// iomem_timer
//   Memory-mapped down-counting timer for the PicoSoC iomem bus.
//
//   Register map (byte offsets, only iomem_addr[4:2] decoded):
//     0x00 CTRL     {bit2 IRQ_EN, bit1 AUTO, bit0 EN}
//     0x04 RELOAD   [COUNT_WIDTH-1:0]
//     0x08 COUNT    [COUNT_WIDTH-1:0]
//     0x0C STATUS   {bit0 EXPIRED}, write-1-to-clear
//     0x10 PRESCALE [15:0]
//     other offsets read 0, writes ignored
//
//   Build option: define TIMER_PRESCALER_EN to include the prescaler. When it
//   is not defined, a tick occurs on every cycle with EN=1, PRESCALE reads 0
//   and writes to it are dropped.
//
//   Parameters:
//     COUNT_WIDTH  width of COUNT/RELOAD (1..32), upper read bits are 0
//
//   Ports:
//     clk          single clock
//     resetn       asynchronous active-low reset
//     iomem_valid  access request (address decode done outside this block)
//     iomem_wstrb  byte write strobes, all zero = read
//     iomem_addr   byte address
//     iomem_wdata  write data
//     iomem_ready  one-cycle access-complete pulse
//     iomem_rdata  read data, valid while iomem_ready is high
//     irq          level interrupt, EXPIRED & IRQ_EN
// ----------------------------------------------------------------------------
module iomem_timer #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_RELOAD   = 3'd1,
        REG_COUNT    = 3'd2,
        REG_STATUS   = 3'd3,
        REG_PRESCALE = 3'd4
    } reg_sel_e;

    // Replace the byte lanes selected by strb, keep the others.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [2:0]             ctrl,   ctrl_d;
    logic [COUNT_WIDTH-1:0] reload, reload_d;
    logic [COUNT_WIDTH-1:0] count,  count_d;
    logic                   expired, expired_d;
`ifdef TIMER_PRESCALER_EN
    logic [15:0]            prescale, prescale_d;
    logic [15:0]            presc_cnt;
`endif

    logic        access;
    logic        bus_wr;
    logic        tick;
    logic        expire_evt;
    logic        status_clr;
    reg_sel_e    sel;
    logic [31:0] rd_val;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{iomem_addr[31:5], iomem_addr[1:0]};

    // An access is taken only while ready is low, so a request held across
    // the ready cycle is not serviced a second time.
    assign access = iomem_valid & ~iomem_ready;
    assign bus_wr = access & (|iomem_wstrb);
    assign sel    = reg_sel_e'(iomem_addr[4:2]);

`ifdef TIMER_PRESCALER_EN
    // >= rather than == so that shrinking PRESCALE below the running
    // prescaler value cannot make it wrap through 65536.
    assign tick = ctrl[0] & (presc_cnt >= prescale);
`else
    assign tick = ctrl[0];
`endif

    assign expire_evt = tick & (count == '0);
    assign status_clr = bus_wr & (sel == REG_STATUS) & iomem_wstrb[0] & iomem_wdata[0];

    assign irq = expired & ctrl[2];

    // Read mux
    always_comb begin
        rd_val = '0;
        case (sel)
            REG_CTRL:     rd_val[2:0]             = ctrl;
            REG_RELOAD:   rd_val[COUNT_WIDTH-1:0] = reload;
            REG_COUNT:    rd_val[COUNT_WIDTH-1:0] = count;
            REG_STATUS:   rd_val[0]               = expired;
            REG_PRESCALE: begin
`ifdef TIMER_PRESCALER_EN
                rd_val[15:0] = prescale;
`endif
            end
            default:      rd_val                  = '0;
        endcase
    end

    // Timer update first, then bus writes on top so a write to COUNT or
    // CTRL overrides the timer's own change in the same cycle. EXPIRED is
    // the exception: a set from expiry beats a simultaneous W1C.
    always_comb begin
        ctrl_d   = ctrl;
        reload_d = reload;
        count_d  = count;
`ifdef TIMER_PRESCALER_EN
        prescale_d = prescale;
`endif

        if (tick) begin
            if (count == '0) begin
                if (ctrl[1]) begin
                    count_d = reload;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end else begin
                count_d = count - COUNT_WIDTH'(1);
            end
        end

        if (bus_wr) begin
            case (sel)
                REG_CTRL:   ctrl_d   = 3'(byte_merge(32'(ctrl_d), iomem_wdata, iomem_wstrb));
                REG_RELOAD: reload_d = COUNT_WIDTH'(byte_merge(32'(reload), iomem_wdata, iomem_wstrb));
                REG_COUNT:  count_d  = COUNT_WIDTH'(byte_merge(32'(count), iomem_wdata, iomem_wstrb));
                REG_PRESCALE: begin
`ifdef TIMER_PRESCALER_EN
                    prescale_d = 16'(byte_merge(32'(prescale), iomem_wdata, iomem_wstrb));
`endif
                end
                default: ;
            endcase
        end

        expired_d = (expired & ~status_clr) | expire_evt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl        <= '0;
            reload      <= '0;
            count       <= '0;
            expired     <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            ctrl        <= ctrl_d;
            reload      <= reload_d;
            count       <= count_d;
            expired     <= expired_d;
            iomem_ready <= access;
            if (access) begin
                iomem_rdata <= rd_val;
            end
        end
    end

`ifdef TIMER_PRESCALER_EN
    // Prescaler sits at 0 while disabled, so the cycle after EN is written
    // starts counting from 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale  <= '0;
            presc_cnt <= '0;
        end else begin
            prescale <= prescale_d;
            if (!ctrl[0] || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
